wrr_bus_arbiter: RTL and testbench
==================================

WRR_BUS_ARBITER -- requirements
Module: wrr_bus_arbiter

Interface
REQ-001 Parameter HOSTS, default 4, number of host ports (2..16).
REQ-002 Parameter ADDR_W, default 32, address width.
REQ-003 Parameter DATA_W, default 32, data width; byte-enable width SHALL be DATA_W/8.
REQ-004 Parameter QUOTA_W, default 4, width of per-host grant quota.
REQ-005 Parameter TIMEOUT, default 255, max cycles waiting for slave ack_bus (1..65535).
REQ-006 Parameter PRIO_CPU, default 1, 1 = cpu-flagged requests win over non-cpu requests.
REQ-007 Ports: one clock and one reset, asynchronous active-low.
REQ-008 clk  in  1  sole clock, rising edge.
REQ-009 reset_n  in  1  asynchronous active-low reset.
REQ-010 addr[HOSTS]  in  ADDR_W  host address.
REQ-011 rd[HOSTS] / wr[HOSTS]  in  1 each  host read / write request.
REQ-012 be[HOSTS]  in  DATA_W/8  host byte enables.
REQ-013 dwr[HOSTS]  in  DATA_W  host write data.
REQ-014 cpu[HOSTS]  in  1  host CPU-origin flag.
REQ-015 quota[HOSTS]  in  QUOTA_W  consecutive grants allowed per turn; 0 treated as 1.
REQ-016 drd[HOSTS]  out  DATA_W  read data to host.
REQ-017 ack[HOSTS]  out  2  00 none, 01 ok, 10 timeout error, 11 protocol error.
REQ-018 add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus  out  slave-side copies of granted host's addr/be/wr/rd/dwr/cpu.
REQ-019 data_bus_rd  in  DATA_W;  ack_bus  in  1  slave read data and completion.

Function
REQ-020 FSM states IDLE, BUS, RESP; all outputs registered.
REQ-021 IDLE: host requests when rd^wr or rd&wr; no request -> stay IDLE, all slave strobes 0.
REQ-022 Selection: round-robin from pointer ptr; with PRIO_CPU=1, choose among cpu=1 requesters first, else among all.
REQ-023 Host with rd=wr=1 selected -> no bus cycle; RESP with ack=11.
REQ-024 Valid selection in IDLE at cycle N -> BUS; slave outputs driven from cycle N+1, held constant until exit.
REQ-025 BUS: ack_bus=1 -> capture data_bus_rd (reads only), deassert rd_bus/wr_bus next cycle, go RESP, response 01.
REQ-026 BUS: TIMEOUT cycles without ack_bus -> abort, strobes 0, RESP, response 10; ack_bus arriving afterwards ignored.
REQ-027 RESP: ack[g]=code for exactly one cycle, drd[g]=captured data (0 for writes/errors), then IDLE; other hosts' ack stay 00.
REQ-028 Minimum transaction: request seen cycle 0, rd_bus cycle 1, ack_bus cycle 1 -> ack[g] cycle 2; next grant earliest from IDLE cycle 3.
REQ-029 Host SHALL hold request fields stable until ack != 00 and drop rd/wr the next cycle; arbiter does not check this.
REQ-030 Quota: credit counter for current grantee; ptr stays on g while g requests and credits < max(quota[g],1); else ptr <= g+1 mod HOSTS.
REQ-031 Credit counter resets to 1 on grant to a different host; saturates at 2^QUOTA_W-1.
REQ-032 Error responses (10, 11) consume credit like ok responses.
REQ-033 quota[] sampled at grant time; changes mid-transaction take effect next grant.

Reset
REQ-034 reset_n low -> state IDLE, ptr 0, credit 0, timeout counter 0, all ack 00, drd 0, all slave outputs 0, immediately.
REQ-035 Reset mid-BUS aborts the transaction with no ack; slave strobes drop asynchronously.
REQ-036 First grant after reset release evaluated on the first rising edge with reset_n high.

Structure
REQ-037 Package arb_pkg: ack code enum (ACK_NONE, ACK_OK, ACK_TMO, ACK_PROTO), FSM state enum.
REQ-038 One sub-module wrr_pick: combinational round-robin picker (request vector, cpu mask, ptr -> one-hot grant, valid).
REQ-039 Timeout counter width $clog2(TIMEOUT+1).

Verification
REQ-040 Hosts 0..3 read continuously, quota all 1, ack_bus 1 cycle after rd_bus -> grants 0,1,2,3,0, each ack[i]=01 with drd = slave data.
REQ-041 quota={3,1,1,1}, all request -> grant sequence 0,0,0,1,2,3,0,0,0.
REQ-042 PRIO_CPU=1, host 2 cpu=1, host 0 cpu=0, ptr=0, both request -> host 2 granted first.
REQ-043 TIMEOUT=8, slave never acks -> rd_bus high exactly 8 cycles, ack[g]=10, drd=0, late ack_bus ignored.
REQ-044 Host 1 rd=wr=1 -> no rd_bus/wr_bus pulse, ack[1]=11 one cycle.
REQ-045 reset_n low during BUS -> all outputs 0 same cycle, no ack; after release next grant starts from host 0.

Source files
------------

// File: rtl/wrr_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : arb_pkg
//  Purpose  : Shared types for the weighted round-robin bus arbiter
//             (host response codes and control FSM states).
//  Revision : 1.0  initial release
// ============================================================================
package arb_pkg;

    // Per-host response code driven on ack[] for one cycle
    typedef enum logic [1:0] {
        ACK_NONE  = 2'b00,
        ACK_OK    = 2'b01,
        ACK_TMO   = 2'b10,
        ACK_PROTO = 2'b11
    } ack_e;

    // Arbiter control FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/wrr_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface : wrr_bus_arbiter_if
//  Purpose   : Bundles the host-side request/response arrays and the single
//              slave-side bus of the arbiter.
//              slave  : view of the arbiter (serves the hosts, drives the bus)
//              master : view of the environment (hosts + slave device)
//  Revision  : 1.0  initial release
// ============================================================================
interface wrr_bus_arbiter_if #(
    parameter int HOSTS   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int QUOTA_W = 4
);
    // Host side
    logic [HOSTS-1:0][ADDR_W-1:0]   addr;
    logic [HOSTS-1:0]               rd;
    logic [HOSTS-1:0]               wr;
    logic [HOSTS-1:0][DATA_W/8-1:0] be;
    logic [HOSTS-1:0][DATA_W-1:0]   dwr;
    logic [HOSTS-1:0]               cpu;
    logic [HOSTS-1:0][QUOTA_W-1:0]  quota;
    logic [HOSTS-1:0][DATA_W-1:0]   drd;
    logic [HOSTS-1:0][1:0]          ack;

    // Slave side
    logic [ADDR_W-1:0]              add_bus;
    logic [DATA_W/8-1:0]            byte_en;
    logic                           wr_bus;
    logic                           rd_bus;
    logic [DATA_W-1:0]              data_bus_wr;
    logic                           cpu_bus;
    logic [DATA_W-1:0]              data_bus_rd;
    logic                           ack_bus;

    modport slave (
        input  addr, rd, wr, be, dwr, cpu, quota, data_bus_rd, ack_bus,
        output drd, ack, add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus
    );

    modport master (
        output addr, rd, wr, be, dwr, cpu, quota, data_bus_rd, ack_bus,
        input  drd, ack, add_bus, byte_en, wr_bus, rd_bus, data_bus_wr, cpu_bus
    );

endinterface
`default_nettype wire

// File: rtl/wrr_bus_arbiter_pick.sv
`default_nettype none
// ============================================================================
//  Module   : wrr_pick
//  Purpose  : Combinational round-robin picker. Searches the candidate set
//             starting at ptr and returns a one-hot grant. When cpu priority
//             is enabled and any cpu-flagged host requests, only those hosts
//             are candidates.
//  Revision : 1.0  initial release
// ============================================================================
module wrr_pick #(
    parameter int HOSTS    = 4,
    parameter int PRIO_CPU = 1,
    parameter int PTR_W    = 2
) (
    input  wire logic [HOSTS-1:0] req,
    input  wire logic [HOSTS-1:0] cpu_mask,
    input  wire logic [PTR_W-1:0] ptr,
    output logic      [HOSTS-1:0] grant,
    output logic                  valid
);

    logic [HOSTS-1:0] cand;

    // Narrow the candidate set to cpu requesters when they exist
    always_comb begin
        cand = req;
        if ((PRIO_CPU != 0) && (|(req & cpu_mask))) begin
            cand = req & cpu_mask;
        end
    end

    // First candidate at or after ptr, wrapping around
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int i = 0; i < HOSTS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= HOSTS) begin
                idx = idx - HOSTS;
            end
            if (!valid && cand[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wrr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wrr_bus_arbiter
//  Purpose  : Weighted round-robin arbiter sharing one slave bus among HOSTS
//             masters. IDLE picks a host, BUS runs the slave cycle with a
//             timeout, RESP returns a one-cycle response code to the host.
//             All outputs are registered.
//  Revision : 1.0  initial release
// ============================================================================
module wrr_bus_arbiter
    import arb_pkg::*;
#(
    parameter int HOSTS    = 4,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int QUOTA_W  = 4,
    parameter int TIMEOUT  = 255,
    parameter int PRIO_CPU = 1
) (
    input  wire logic        clk,
    input  wire logic        reset_n,
    wrr_bus_arbiter_if.slave bus
);

    localparam int PTR_W = $clog2(HOSTS);
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam int BE_W  = DATA_W / 8;

    localparam logic [QUOTA_W-1:0] CREDIT_ONE = QUOTA_W'(1);
    localparam logic [QUOTA_W-1:0] CREDIT_MAX = '1;
    localparam logic [TMO_W-1:0]   TMO_LAST   = TMO_W'(TIMEOUT - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(HOSTS - 1);

    state_e                        state_q, state_d;
    logic [PTR_W-1:0]              ptr_q, ptr_d;
    logic [PTR_W-1:0]              cur_q, cur_d;
    logic [QUOTA_W-1:0]            credit_q, credit_d;
    logic [TMO_W-1:0]              tmo_q, tmo_d;

    logic [ADDR_W-1:0]             add_q, add_d;
    logic [BE_W-1:0]               be_q, be_d;
    logic [DATA_W-1:0]             dwr_q, dwr_d;
    logic                          rd_q, rd_d;
    logic                          wr_q, wr_d;
    logic                          cpu_q, cpu_d;
    logic [HOSTS-1:0][1:0]         ack_q, ack_d;
    logic [HOSTS-1:0][DATA_W-1:0]  drd_q, drd_d;

    logic [HOSTS-1:0]              req;
    logic [HOSTS-1:0]              pick_onehot;
    logic                          pick_valid;
    logic [PTR_W-1:0]              pick_idx;
    logic [QUOTA_W-1:0]            quota_eff;
    logic [QUOTA_W-1:0]            credit_new;

    // A host requests with rd, wr, or both (both becomes a protocol error)
    assign req = bus.rd | bus.wr;

    wrr_pick #(
        .HOSTS    (HOSTS),
        .PRIO_CPU (PRIO_CPU),
        .PTR_W    (PTR_W)
    ) u_pick (
        .req      (req),
        .cpu_mask (bus.cpu),
        .ptr      (ptr_q),
        .grant    (pick_onehot),
        .valid    (pick_valid)
    );

    // One-hot to index for the picked host
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < HOSTS; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    // Credit the picked host would hold after this grant, and its quota
    always_comb begin
        quota_eff = (bus.quota[pick_idx] == '0) ? CREDIT_ONE : bus.quota[pick_idx];
        if ((credit_q == '0) || (cur_q != pick_idx)) begin
            credit_new = CREDIT_ONE;
        end else if (credit_q == CREDIT_MAX) begin
            credit_new = credit_q;
        end else begin
            credit_new = credit_q + CREDIT_ONE;
        end
    end

    // Next-state and next-output logic; responses default to a single cycle
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        credit_d = credit_q;
        tmo_d    = tmo_q;
        add_d    = add_q;
        be_d     = be_q;
        dwr_d    = dwr_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        cpu_d    = cpu_q;
        ack_d    = '0;
        drd_d    = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    // Grant bookkeeping is identical for good and bad requests
                    cur_d    = pick_idx;
                    credit_d = credit_new;
                    ptr_d    = (credit_new < quota_eff) ? pick_idx :
                               ((pick_idx == PTR_LAST) ? '0 : pick_idx + 1'b1);
                    tmo_d    = '0;
                    if (bus.rd[pick_idx] && bus.wr[pick_idx]) begin
                        state_d         = ST_RESP;
                        ack_d[pick_idx] = ACK_PROTO;
                    end else begin
                        state_d = ST_BUS;
                        add_d   = bus.addr[pick_idx];
                        be_d    = bus.be[pick_idx];
                        dwr_d   = bus.dwr[pick_idx];
                        rd_d    = bus.rd[pick_idx];
                        wr_d    = bus.wr[pick_idx];
                        cpu_d   = bus.cpu[pick_idx];
                    end
                end
            end

            ST_BUS: begin
                if (bus.ack_bus || (tmo_q == TMO_LAST)) begin
                    state_d = ST_RESP;
                    if (bus.ack_bus) begin
                        ack_d[cur_q] = ACK_OK;
                        if (rd_q) begin
                            drd_d[cur_q] = bus.data_bus_rd;
                        end
                    end else begin
                        ack_d[cur_q] = ACK_TMO;
                    end
                    // Leave the slave bus fully quiet between transactions
                    add_d = '0;
                    be_d  = '0;
                    dwr_d = '0;
                    rd_d  = 1'b0;
                    wr_d  = 1'b0;
                    cpu_d = 1'b0;
                    tmo_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Arbitration bookkeeping and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q    <= '0;
            cur_q    <= '0;
            credit_q <= '0;
            tmo_q    <= '0;
            add_q    <= '0;
            be_q     <= '0;
            dwr_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cpu_q    <= 1'b0;
            ack_q    <= '0;
            drd_q    <= '0;
        end else begin
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            credit_q <= credit_d;
            tmo_q    <= tmo_d;
            add_q    <= add_d;
            be_q     <= be_d;
            dwr_q    <= dwr_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            cpu_q    <= cpu_d;
            ack_q    <= ack_d;
            drd_q    <= drd_d;
        end
    end

    assign bus.add_bus     = add_q;
    assign bus.byte_en     = be_q;
    assign bus.data_bus_wr = dwr_q;
    assign bus.rd_bus      = rd_q;
    assign bus.wr_bus      = wr_q;
    assign bus.cpu_bus     = cpu_q;
    assign bus.ack         = ack_q;
    assign bus.drd         = drd_q;

endmodule
`default_nettype wire

// File: tb/tb_wrr_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wrr_bus_arbiter
//  Purpose  : Directed self-checking bench for wrr_bus_arbiter (4 hosts,
//             TIMEOUT 8, cpu priority on).
//  Revision : 1.0  initial release
// ============================================================================
module tb_wrr_bus_arbiter;
    import arb_pkg::*;

    localparam int HOSTS    = 4;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int QUOTA_W  = 4;
    localparam int TIMEOUT  = 8;
    localparam int PRIO_CPU = 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    wrr_bus_arbiter_if #(
        .HOSTS(HOSTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUOTA_W(QUOTA_W)
    ) bif ();

    wrr_bus_arbiter #(
        .HOSTS(HOSTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .QUOTA_W(QUOTA_W),
        .TIMEOUT(TIMEOUT), .PRIO_CPU(PRIO_CPU)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Response log: one entry per cycle in which any ack is non-zero
    int          log_host[$];
    int          log_code[$];
    logic [31:0] log_drd[$];
    int          log_cyc[$];

    logic [HOSTS-1:0] oneshot = '0;
    bit               slave_en = 1'b1;
    int               slave_delay = 1;
    int               bus_run = 0;
    int               bus_cycles = 0;
    int               rd_hi = 0;
    logic [31:0]      seen_add = '0;
    logic [31:0]      seen_dwr = '0;
    logic [3:0]       seen_be = '0;
    logic             seen_wr = 1'b0;
    int               c0 = 0;

    function automatic logic [31:0] haddr(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] exp_rdata(input int i);
        return haddr(i) ^ 32'hA5A5_A5A5;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_log(input int j, input int host, input int code,
                           input logic [31:0] drd, input string tag);
        chk({tag, " host"}, (log_host.size() > j) ? 64'(log_host[j]) : 64'hFFFF, 64'(host));
        chk({tag, " code"}, (log_code.size() > j) ? 64'(log_code[j]) : 64'hFFFF, 64'(code));
        chk({tag, " drd"},  (log_drd.size()  > j) ? 64'(log_drd[j])  : 64'hFFFF_FFFF_FFFF, 64'(drd));
    endtask

    // One clock: observe outputs, play host and slave roles for this cycle
    task automatic cycle();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < HOSTS; i++) begin
            if (bif.ack[i] != 2'b00) begin
                log_host.push_back(i);
                log_code.push_back(int'(bif.ack[i]));
                log_drd.push_back(bif.drd[i]);
                log_cyc.push_back(cyc);
                if (oneshot[i]) begin
                    bif.rd[i] = 1'b0;
                    bif.wr[i] = 1'b0;
                end
            end
        end
        if (bif.rd_bus || bif.wr_bus) begin
            if (bus_run == 0) begin
                seen_add = bif.add_bus;
                seen_dwr = bif.data_bus_wr;
                seen_be  = bif.byte_en;
                seen_wr  = bif.wr_bus;
            end
            bus_run++;
            bus_cycles++;
        end else begin
            bus_run = 0;
        end
        if (bif.rd_bus) rd_hi++;
        bif.ack_bus     = slave_en && (bif.rd_bus || bif.wr_bus) && (bus_run == slave_delay + 1);
        bif.data_bus_rd = bif.add_bus ^ 32'hA5A5_A5A5;
    endtask

    task automatic clear_logs();
        log_host.delete();
        log_code.delete();
        log_drd.delete();
        log_cyc.delete();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        bif.rd  = '0;
        bif.wr  = '0;
        bif.cpu = '0;
        for (int i = 0; i < HOSTS; i++) bif.quota[i] = 4'd1;
        oneshot = '0;
        slave_en = 1'b1;
        slave_delay = 1;
        cycle();
        cycle();
        clear_logs();
        bus_run = 0;
        bus_cycles = 0;
        rd_hi = 0;
        reset_n = 1'b1;
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (log_host.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk({tag, " reached"}, 64'(log_host.size() >= n), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < HOSTS; i++) begin
            bif.addr[i]  = haddr(i);
            bif.be[i]    = 4'hF;
            bif.dwr[i]   = 32'hC0DE_0000 + 32'(i);
            bif.quota[i] = 4'd1;
        end
        bif.rd = '0;
        bif.wr = '0;
        bif.cpu = '0;
        bif.ack_bus = 1'b0;
        bif.data_bus_rd = '0;

        // Reset state
        cycle();
        cycle();
        chk("rst ack",     64'(bif.ack), 64'd0);
        chk("rst drd",     64'(bif.drd[0] | bif.drd[1] | bif.drd[2] | bif.drd[3]), 64'd0);
        chk("rst rd_bus",  64'(bif.rd_bus), 64'd0);
        chk("rst wr_bus",  64'(bif.wr_bus), 64'd0);
        chk("rst add_bus", 64'(bif.add_bus), 64'd0);
        chk("rst byte_en", 64'(bif.byte_en), 64'd0);
        chk("rst dwr_bus", 64'(bif.data_bus_wr), 64'd0);
        chk("rst cpu_bus", 64'(bif.cpu_bus), 64'd0);

        // A: four continuous readers, quota 1 -> 0,1,2,3,0
        do_reset();
        bif.rd = 4'b1111;
        run_until(5, 200, "A");
        bif.rd = '0;
        chk_log(0, 0, 1, exp_rdata(0), "A0");
        chk_log(1, 1, 1, exp_rdata(1), "A1");
        chk_log(2, 2, 1, exp_rdata(2), "A2");
        chk_log(3, 3, 1, exp_rdata(3), "A3");
        chk_log(4, 0, 1, exp_rdata(0), "A4");

        // B: quota {3,1,1,1} -> 0,0,0,1,2,3,0,0,0
        do_reset();
        bif.quota[0] = 4'd3;
        bif.rd = 4'b1111;
        run_until(9, 300, "B");
        bif.rd = '0;
        chk_log(0, 0, 1, exp_rdata(0), "B0");
        chk_log(1, 0, 1, exp_rdata(0), "B1");
        chk_log(2, 0, 1, exp_rdata(0), "B2");
        chk_log(3, 1, 1, exp_rdata(1), "B3");
        chk_log(4, 2, 1, exp_rdata(2), "B4");
        chk_log(5, 3, 1, exp_rdata(3), "B5");
        chk_log(6, 0, 1, exp_rdata(0), "B6");
        chk_log(7, 0, 1, exp_rdata(0), "B7");
        chk_log(8, 0, 1, exp_rdata(0), "B8");

        // C: cpu host 2 beats host 0 from ptr 0; zero-wait slave timing
        do_reset();
        slave_delay = 0;
        oneshot = 4'b0101;
        bif.cpu[2] = 1'b1;
        bif.rd[0] = 1'b1;
        bif.rd[2] = 1'b1;
        c0 = cyc;
        run_until(2, 40, "C");
        chk_log(0, 2, 1, exp_rdata(2), "C0");
        chk_log(1, 0, 1, exp_rdata(0), "C1");
        chk("C lat0", (log_cyc.size() > 0) ? 64'(log_cyc[0] - c0) : 64'hFFFF, 64'd2);
        chk("C lat1", (log_cyc.size() > 1) ? 64'(log_cyc[1] - c0) : 64'hFFFF, 64'd5);

        // D: slave never answers -> 8 rd_bus cycles, timeout code, late ack ignored
        do_reset();
        slave_en = 1'b0;
        oneshot = 4'b0010;
        bif.rd[1] = 1'b1;
        run_until(1, 40, "D");
        chk_log(0, 1, 2, 32'h0, "D0");
        chk("D rd_bus cycles", 64'(rd_hi), 64'd8);
        bif.ack_bus = 1'b1;
        cycle();
        bif.ack_bus = 1'b1;
        repeat (4) cycle();
        chk("D late ack entries", 64'(log_host.size()), 64'd1);
        chk("D late rd_bus", 64'(bif.rd_bus), 64'd0);
        chk("D late ack", 64'(bif.ack), 64'd0);

        // E: rd=wr=1 -> protocol error without bus cycle; then a plain write
        do_reset();
        oneshot = 4'b0011;
        bif.rd[1] = 1'b1;
        bif.wr[1] = 1'b1;
        c0 = cyc;
        run_until(1, 20, "E");
        chk_log(0, 1, 3, 32'h0, "E0");
        chk("E lat", (log_cyc.size() > 0) ? 64'(log_cyc[0] - c0) : 64'hFFFF, 64'd1);
        repeat (3) cycle();
        chk("E ack one cycle", 64'(log_host.size()), 64'd1);
        chk("E bus cycles", 64'(bus_cycles), 64'd0);
        bif.dwr[0] = 32'h1234_5678;
        bif.be[0]  = 4'b0110;
        bif.wr[0]  = 1'b1;
        run_until(2, 20, "E wr");
        chk_log(1, 0, 1, 32'h0, "E1");
        chk("E wr_bus", 64'(seen_wr), 64'd1);
        chk("E wdata", 64'(seen_dwr), 64'h1234_5678);
        chk("E byte_en", 64'(seen_be), 64'h6);
        chk("E add_bus", 64'(seen_add), 64'(haddr(0)));

        // F: reset during BUS drops the bus at once; next grant searches from 0
        do_reset();
        slave_en = 1'b0;
        bif.rd[2] = 1'b1;
        for (int k = 0; k < 10 && !bif.rd_bus; k++) cycle();
        chk("F rd_bus up", 64'(bif.rd_bus), 64'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("F async rd_bus", 64'(bif.rd_bus), 64'd0);
        chk("F async add_bus", 64'(bif.add_bus), 64'd0);
        chk("F async ack", 64'(bif.ack), 64'd0);
        bif.rd = 4'b1001;
        oneshot = 4'b1001;
        slave_en = 1'b1;
        cycle();
        cycle();
        chk("F no ack in reset", 64'(log_host.size()), 64'd0);
        reset_n = 1'b1;
        cycle();
        chk("F first grant rd_bus", 64'(bif.rd_bus), 64'd1);
        chk("F first grant addr", 64'(seen_add), 64'(haddr(0)));
        run_until(1, 20, "F");
        chk_log(0, 0, 1, exp_rdata(0), "F0");
        bif.rd = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
